pau_arbiter: RTL and testbench
==============================

Name: pau_arbiter

Overview:
Shares one posit arithmetic unit (PAU: add/mul/div, start/done interface) between NREQ independent requesters, e.g. several CVXIF coprocessor front-ends.
- Arbitrates round-robin and latches the winner's operands.
- Sequences the PAU with a minimum-wait counter and a timeout watchdog.
- Returns the result, tagged, to the owning requester over a valid/ready response channel.

Parameters:
NREQ, 2, number of requesters (2..8)
PAU_N, 16, posit word width
TAG_W, 4, requester-supplied transaction tag width
PAU_WAIT_TIME, 4, minimum RUN cycles before pau_done is honoured
PAU_TIMEOUT, 64, RUN cycles after which the op is abandoned (must exceed PAU_WAIT_TIME)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
req_valid  in  NREQ  per-requester request valid
req_ready  out  NREQ  per-requester grant/accept (one-hot or zero)
req_op  in  NREQ*3  per-requester opcode, requester i at [3i+:3]
req_a  in  NREQ*PAU_N  operand A per requester
req_b  in  NREQ*PAU_N  operand B per requester
req_tag  in  NREQ*TAG_W  tag per requester
resp_valid  out  NREQ  one-hot result valid to owner
resp_ready  in  NREQ  per-requester result accept
resp_data  out  PAU_N  shared result bus, qualified by resp_valid
resp_tag  out  TAG_W  tag of the returned transaction
resp_err  out  1  result is NaR due to timeout or illegal op
busy  out  1  PAU owned (state != IDLE)
pau_op  out  3  opcode to PAU result mux
pau_a, pau_b  out  PAU_N  registered operands to PAU
pau_start  out  1  held high through RUN
pau_done  in  1  PAU completion
pau_result  in  PAU_N  PAU result for pau_op

Behaviour:
- Reset, asynchronous: all outputs 0; state IDLE; counter 0; last_grant = NREQ-1, so requester 0 wins first.
- Reset mid-op: aborts silently. No response is issued.
- States: IDLE, RUN, RESP.
- IDLE:
  - Grant goes to the first requester with req_valid set, scanning from last_grant+1 modulo NREQ.
  - In the same cycle, req_ready[g]=1 (combinational from req_valid).
  - Latch op, a, tag and owner=g.
  - b latch: -b (two's complement) for SUB_OP, otherwise b.
  - Legal op (ADD/SUB/MUL/DIV) -> RUN with counter=0.
  - Illegal op -> RESP with resp_data=NaR (1 followed by zeros), resp_err=1; PAU untouched.
- RUN:
  - pau_start=1; pau_op = ADD_OP for SUB, otherwise the latched op.
  - Counter increments every cycle, saturating at PAU_TIMEOUT.
  - pau_done is ignored while counter < PAU_WAIT_TIME.
  - pau_done with counter >= PAU_WAIT_TIME: capture pau_result, resp_err=0 -> RESP.
  - counter == PAU_TIMEOUT without done: resp_data=NaR, resp_err=1 -> RESP.
- RESP:
  - resp_valid[owner]=1; resp_data, resp_tag, resp_err held stable.
  - On resp_ready[owner]: last_grant=owner -> IDLE.
  - resp_ready from non-owners is ignored.
- Latency: accept at cycle T -> earliest resp_valid at T+PAU_WAIT_TIME+2.
- Minimum one IDLE cycle between ops: no grant in the cycle a response is accepted.
- Requesters may drop req_valid before grant without penalty.
- After grant, a requester's inputs may change freely.
- resp_valid, resp_data, resp_tag and resp_err are registered. busy = (state != IDLE).

Decomposition:
- Package pau_pkg holds:
  - ADD_OP=3'b000, SUB_OP=3'b001, MUL_OP=3'b010, DIV_OP=3'b011
  - state_t enum {IDLE, RUN, RESP}
  - function nar(N)
- Sub-module rr_arbiter (NREQ, request vector + last_grant -> one-hot grant + index): combinational, reusable.

Test Plan:
- Single request: req 0 ADD a=0x4000, b=0x4000, tag=3; PAU model done at counter 4 returns 0x5000 -> resp_valid=2'b01 at T+6, resp_data=0x5000, resp_tag=3, resp_err=0.
- Contention: both requesters valid continuously from reset -> grants alternate 0,1,0,1. Each grant occurs only from IDLE; the next grant comes one cycle after the previous resp accept.
- SUB: req 1 SUB a=0x5800, b=0x4000 -> pau_op=ADD_OP, pau_b=0xC000. An early done at counter 2 is ignored; result taken at counter>=4.
- Timeout: PAU never asserts done -> resp_err=1, resp_data=0x8000 after PAU_TIMEOUT+1 RUN cycles; the arbiter then accepts a new request.
- Illegal op 3'b111 -> granted, resp at T+1 with NaR, resp_err=1, pau_start never asserted.
- Async reset asserted in RUN with resp_ready held low -> all outputs 0 immediately; after release, requester 0 wins first grant.

Source files
------------

// File: rtl/pau_pkg.sv
// Shared opcodes, FSM state type and posit helpers for the PAU arbiter.
package pau_pkg;

    localparam logic [2:0] ADD_OP = 3'b000;
    localparam logic [2:0] SUB_OP = 3'b001;
    localparam logic [2:0] MUL_OP = 3'b010;
    localparam logic [2:0] DIV_OP = 3'b011;

    localparam int NAR_MAX_W = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        RESP = 2'd2
    } state_t;

    // Posit NaR: sign bit set, all other bits clear. Callers slice to their width.
    function automatic logic [NAR_MAX_W-1:0] nar(input int n);
        logic [NAR_MAX_W-1:0] one;
        one = NAR_MAX_W'(1);
        return one << (n - 1);
    endfunction

    function automatic logic is_legal_op(input logic [2:0] op);
        return (op == ADD_OP) || (op == SUB_OP) || (op == MUL_OP) || (op == DIV_OP);
    endfunction

endpackage

// File: rtl/pau_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: the first request found scanning upward
// from last_grant+1 (modulo NREQ) wins.
module rr_arbiter #(
    parameter int NREQ = 2,
    localparam int IW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   last_grant,
    output logic [NREQ-1:0] grant,
    output logic [IW-1:0]   grant_idx,
    output logic            grant_valid
);

    always_comb begin
        int cand;
        cand        = 0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        // Walk from the lowest priority offset down so the highest priority hit is written last.
        for (int k = NREQ; k >= 1; k--) begin
            cand = (int'(last_grant) + k) % NREQ;
            if (req[cand]) begin
                grant_idx   = IW'(cand);
                grant_valid = 1'b1;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_onehot
            assign grant[gi] = grant_valid && (grant_idx == IW'(gi));
        end
    endgenerate

endmodule

// File: rtl/pau_arbiter.sv
// Shares one start/done posit arithmetic unit between NREQ requesters with
// round-robin arbitration, a minimum-wait counter and a timeout watchdog.
module pau_arbiter
    import pau_pkg::*;
#(
    parameter int NREQ          = 2,
    parameter int PAU_N         = 16,
    parameter int TAG_W         = 4,
    parameter int PAU_WAIT_TIME = 4,
    parameter int PAU_TIMEOUT   = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req_valid,
    output logic [NREQ-1:0]        req_ready,
    input  logic [NREQ*3-1:0]      req_op,
    input  logic [NREQ*PAU_N-1:0]  req_a,
    input  logic [NREQ*PAU_N-1:0]  req_b,
    input  logic [NREQ*TAG_W-1:0]  req_tag,
    output logic [NREQ-1:0]        resp_valid,
    input  logic [NREQ-1:0]        resp_ready,
    output logic [PAU_N-1:0]       resp_data,
    output logic [TAG_W-1:0]       resp_tag,
    output logic                   resp_err,
    output logic                   busy,
    output logic [2:0]             pau_op,
    output logic [PAU_N-1:0]       pau_a,
    output logic [PAU_N-1:0]       pau_b,
    output logic                   pau_start,
    input  logic                   pau_done,
    input  logic [PAU_N-1:0]       pau_result
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(PAU_TIMEOUT + 1);
    localparam logic [CW-1:0] WAIT_C = CW'(PAU_WAIT_TIME);
    localparam logic [CW-1:0] TMO_C  = CW'(PAU_TIMEOUT);
    localparam logic [NAR_MAX_W-1:0] NAR_FULL = nar(PAU_N);
    localparam logic [PAU_N-1:0] NAR_W = NAR_FULL[PAU_N-1:0];
    localparam logic [NREQ-1:0] ONE_HOT0 = NREQ'(1);

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [IW-1:0]     last_grant_q, last_grant_d;
    logic [IW-1:0]     owner_q, owner_d;
    logic [2:0]        pau_op_q, pau_op_d;
    logic [PAU_N-1:0]  pau_a_q, pau_a_d;
    logic [PAU_N-1:0]  pau_b_q, pau_b_d;
    logic              pau_start_q, pau_start_d;
    logic [NREQ-1:0]   resp_valid_q, resp_valid_d;
    logic [PAU_N-1:0]  resp_data_q, resp_data_d;
    logic [TAG_W-1:0]  resp_tag_q, resp_tag_d;
    logic              resp_err_q, resp_err_d;

    logic [NREQ-1:0]   grant;
    logic [IW-1:0]     grant_idx;
    logic              grant_valid;
    logic [2:0]        op_sel;
    logic [PAU_N-1:0]  a_sel;
    logic [PAU_N-1:0]  b_sel;
    logic [TAG_W-1:0]  tag_sel;

    rr_arbiter #(.NREQ(NREQ)) u_rr (
        .req         (req_valid),
        .last_grant  (last_grant_q),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    assign op_sel  = req_op[int'(grant_idx)*3 +: 3];
    assign a_sel   = req_a[int'(grant_idx)*PAU_N +: PAU_N];
    assign b_sel   = req_b[int'(grant_idx)*PAU_N +: PAU_N];
    assign tag_sel = req_tag[int'(grant_idx)*TAG_W +: TAG_W];

    // Ready is combinational so a requester is accepted in the cycle it is granted.
    assign req_ready  = (state_q == IDLE && !rst) ? grant : '0;
    assign busy       = (state_q != IDLE);
    assign pau_op     = pau_op_q;
    assign pau_a      = pau_a_q;
    assign pau_b      = pau_b_q;
    assign pau_start  = pau_start_q;
    assign resp_valid = resp_valid_q;
    assign resp_data  = resp_data_q;
    assign resp_tag   = resp_tag_q;
    assign resp_err   = resp_err_q;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        pau_op_d     = pau_op_q;
        pau_a_d      = pau_a_q;
        pau_b_d      = pau_b_q;
        pau_start_d  = pau_start_q;
        resp_valid_d = resp_valid_q;
        resp_data_d  = resp_data_q;
        resp_tag_d   = resp_tag_q;
        resp_err_d   = resp_err_q;

        case (state_q)
            IDLE: begin
                if (grant_valid) begin
                    owner_d    = grant_idx;
                    resp_tag_d = tag_sel;
                    if (is_legal_op(op_sel)) begin
                        // Subtraction runs on the adder with a negated B operand.
                        pau_op_d    = (op_sel == SUB_OP) ? ADD_OP : op_sel;
                        pau_a_d     = a_sel;
                        pau_b_d     = (op_sel == SUB_OP) ? -b_sel : b_sel;
                        pau_start_d = 1'b1;
                        cnt_d       = '0;
                        state_d     = RUN;
                    end else begin
                        resp_data_d  = NAR_W;
                        resp_err_d   = 1'b1;
                        resp_valid_d = grant;
                        state_d      = RESP;
                    end
                end
            end
            RUN: begin
                if (cnt_q != TMO_C) begin
                    cnt_d = cnt_q + 1'b1;
                end
                if (pau_done && cnt_q >= WAIT_C) begin
                    resp_data_d  = pau_result;
                    resp_err_d   = 1'b0;
                    resp_valid_d = ONE_HOT0 << owner_q;
                    pau_start_d  = 1'b0;
                    state_d      = RESP;
                end else if (cnt_q == TMO_C) begin
                    resp_data_d  = NAR_W;
                    resp_err_d   = 1'b1;
                    resp_valid_d = ONE_HOT0 << owner_q;
                    pau_start_d  = 1'b0;
                    state_d      = RESP;
                end
            end
            RESP: begin
                if (resp_ready[owner_q]) begin
                    resp_valid_d = '0;
                    last_grant_d = owner_q;
                    state_d      = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            last_grant_q <= IW'(NREQ - 1);
            owner_q      <= '0;
            pau_op_q     <= '0;
            pau_a_q      <= '0;
            pau_b_q      <= '0;
            pau_start_q  <= 1'b0;
            resp_valid_q <= '0;
            resp_data_q  <= '0;
            resp_tag_q   <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            pau_op_q     <= pau_op_d;
            pau_a_q      <= pau_a_d;
            pau_b_q      <= pau_b_d;
            pau_start_q  <= pau_start_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            resp_tag_q   <= resp_tag_d;
            resp_err_q   <= resp_err_d;
        end
    end

endmodule

// File: tb/tb_pau_arbiter.sv
// Directed bench for pau_arbiter with a behavioural PAU and a response scoreboard.
module tb_pau_arbiter;
    import pau_pkg::*;

    localparam int NREQ  = 2;
    localparam int PN    = 16;
    localparam int TW    = 4;
    localparam int WT    = 4;
    localparam int TMO   = 64;

    logic              clk;
    logic              rst;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*3-1:0] req_op;
    logic [NREQ*PN-1:0] req_a;
    logic [NREQ*PN-1:0] req_b;
    logic [NREQ*TW-1:0] req_tag;
    logic [NREQ-1:0]   resp_valid;
    logic [NREQ-1:0]   resp_ready;
    logic [PN-1:0]     resp_data;
    logic [TW-1:0]     resp_tag;
    logic              resp_err;
    logic              busy;
    logic [2:0]        pau_op;
    logic [PN-1:0]     pau_a;
    logic [PN-1:0]     pau_b;
    logic              pau_start;
    logic              pau_done;
    logic [PN-1:0]     pau_result;

    typedef struct {
        int          owner;
        logic [PN-1:0] data;
        logic [TW-1:0] tag;
        logic        err;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    pau_arbiter #(
        .NREQ(NREQ), .PAU_N(PN), .TAG_W(TW),
        .PAU_WAIT_TIME(WT), .PAU_TIMEOUT(TMO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_tag    (req_tag),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_tag   (resp_tag),
        .resp_err   (resp_err),
        .busy       (busy),
        .pau_op     (pau_op),
        .pau_a      (pau_a),
        .pau_b      (pau_b),
        .pau_start  (pau_start),
        .pau_done   (pau_done),
        .pau_result (pau_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural PAU: counts RUN cycles from 0 and raises done at chosen counts.
    int            pau_cnt;
    int            done_at  = -1;
    int            early_at = -1;
    logic [PN-1:0] model_res = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) pau_cnt <= 0;
        else     pau_cnt <= pau_start ? pau_cnt + 1 : 0;
    end

    assign pau_done   = pau_start && (pau_cnt == done_at || pau_cnt == early_at);
    assign pau_result = pau_start ? model_res : '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_resp(input int k);
        exp_t e;
        logic [NREQ-1:0] oh;
        if (sb.size() == 0) begin
            chk("sb_empty", 32'(sb.size()), 1);
        end else begin
            e  = sb.pop_front();
            oh = NREQ'(1) << e.owner;
            chk("latency", 32'(k), 32'(e.lat));
            chk("resp_valid", 32'(resp_valid), 32'(oh));
            chk("resp_data", 32'(resp_data), 32'(e.data));
            chk("resp_tag", 32'(resp_tag), 32'(e.tag));
            chk("resp_err", 32'(resp_err), 32'(e.err));
            $display("txn req%0d tag=%0h data=%h err=%0b latency=%0d", e.owner, resp_tag, resp_data, resp_err, k);
        end
    endtask

    task automatic do_txn(input int idx, input logic [2:0] op, input logic [PN-1:0] a,
                          input logic [PN-1:0] b, input logic [TW-1:0] tag,
                          input logic [PN-1:0] res, input int d_at, input int e_at,
                          input int lat, input logic [PN-1:0] exp_data, input logic exp_err,
                          input logic exp_start, input logic sub_chk);
        logic [NREQ-1:0] oh;
        logic saw_start;
        int k;
        oh = NREQ'(1) << idx;
        k = 0;
        while (busy !== 1'b0 && k < 200) begin tick(); k++; end
        chk("idle_before_req", 32'(busy), 0);
        model_res = res; done_at = d_at; early_at = e_at;
        req_valid[idx] = 1'b1;
        req_op[idx*3 +: 3]   = op;
        req_a[idx*PN +: PN]  = a;
        req_b[idx*PN +: PN]  = b;
        req_tag[idx*TW +: TW] = tag;
        #1;
        chk("grant", 32'(req_ready), 32'(oh));
        sb.push_back('{idx, exp_data, tag, exp_err, lat});
        saw_start = 1'b0;
        k = 0;
        do begin
            tick();
            k++;
            if (pau_start) saw_start = 1'b1;
            if (k == 1) begin
                req_valid[idx] = 1'b0;
                req_a[idx*PN +: PN] = PN'($urandom);
                req_b[idx*PN +: PN] = PN'($urandom);
                req_tag[idx*TW +: TW] = TW'($urandom);
                req_op[idx*3 +: 3] = 3'($urandom);
                chk("pau_start_run", 32'(pau_start), 32'(exp_start));
                if (sub_chk) begin
                    chk("sub_pau_op", 32'(pau_op), 32'(ADD_OP));
                    chk("sub_pau_a", 32'(pau_a), 32'(a));
                    chk("sub_pau_b", 32'(pau_b), 32'h0000C000);
                end
            end
        end while (resp_valid == '0 && k < 300);
        check_resp(k);
        chk("pau_start_seen", 32'(saw_start), 32'(exp_start));
        resp_ready = ~oh;
        tick();
        chk("nonowner_ready_ignored", 32'(resp_valid), 32'(oh));
        resp_ready = oh;
        tick();
        resp_ready = '0;
        chk("after_accept_busy", 32'(busy), 0);
        chk("after_accept_valid", 32'(resp_valid), 0);
    endtask

    initial begin
        logic [NREQ-1:0] oh;
        int k;
        rst = 1'b1;
        req_valid = '0; resp_ready = '0;
        req_op = '0; req_a = '0; req_b = '0; req_tag = '0;
        repeat (3) tick();

        // Reset state
        chk("rst_busy", 32'(busy), 0);
        chk("rst_resp_valid", 32'(resp_valid), 0);
        chk("rst_pau_start", 32'(pau_start), 0);
        chk("rst_resp_data", 32'(resp_data), 0);
        chk("rst_pau_a", 32'(pau_a), 0);

        // Contention: both requesters valid from reset, grants must alternate 0,1,0,1
        req_valid = 2'b11;
        req_op    = {3'(ADD_OP), 3'(ADD_OP)};
        req_a     = {16'h4000, 16'h3000};
        req_b     = {16'h4000, 16'h3000};
        req_tag   = {4'hB, 4'hA};
        #1;
        chk("rst_ready_gated", 32'(req_ready), 0);
        model_res = 16'h1234; done_at = WT; early_at = -1;
        tick();
        rst = 1'b0;
        for (int g = 0; g < 4; g++) begin
            oh = (g % 2 == 0) ? 2'b01 : 2'b10;
            #1;
            chk("cont_grant", 32'(req_ready), 32'(oh));
            chk("cont_busy", 32'(busy), 0);
            sb.push_back('{g % 2, 16'h1234, (g % 2 == 0) ? 4'hA : 4'hB, 1'b0, WT + 2});
            k = 0;
            do begin tick(); k++; end while (resp_valid == '0 && k < 300);
            check_resp(k);
            resp_ready = oh;
            #1;
            chk("cont_no_grant_in_accept", 32'(req_ready), 0);
            tick();
            resp_ready = '0;
            if (g == 3) req_valid = '0;
        end

        // Single ADD on requester 0
        do_txn(0, ADD_OP, 16'h4000, 16'h4000, 4'h3, 16'h5000, WT, -1, WT + 2, 16'h5000, 1'b0, 1'b1, 1'b0);
        // SUB on requester 1 with an early done at count 2 that must be ignored
        do_txn(1, SUB_OP, 16'h5800, 16'h4000, 4'h7, 16'h5000, WT, 2, WT + 2, 16'h5000, 1'b0, 1'b1, 1'b1);
        // Illegal opcode: NaR straight back, PAU never started
        do_txn(1, 3'b111, 16'h1111, 16'h2222, 4'h5, 16'h0000, -1, -1, 1, 16'h8000, 1'b1, 1'b0, 1'b0);
        // Timeout: PAU never completes
        do_txn(0, MUL_OP, 16'h4000, 16'h5000, 4'h9, 16'h6000, -1, -1, TMO + 2, 16'h8000, 1'b1, 1'b1, 1'b0);

        // Async reset in RUN: req 0 running, last_grant is 0 so req 1 would win without reset
        done_at = -1; early_at = -1;
        req_valid = 2'b01;
        req_op[2:0] = ADD_OP; req_a[15:0] = 16'h4000; req_b[15:0] = 16'h4000; req_tag[3:0] = 4'hC;
        #1;
        chk("rst_run_grant", 32'(req_ready), 32'h1);
        repeat (3) tick();
        req_valid = 2'b11;
        chk("rst_run_started", 32'(pau_start), 1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_busy", 32'(busy), 0);
        chk("arst_pau_start", 32'(pau_start), 0);
        chk("arst_req_ready", 32'(req_ready), 0);
        chk("arst_pau_a", 32'(pau_a), 0);
        chk("arst_pau_b", 32'(pau_b), 0);
        chk("arst_resp_valid", 32'(resp_valid), 0);
        chk("arst_resp_tag", 32'(resp_tag), 0);
        repeat (2) tick();
        rst = 1'b0;
        #1;
        chk("post_rst_grant", 32'(req_ready), 32'h1);
        req_valid = '0;
        k = 0;
        repeat (5) begin
            tick();
            if (resp_valid != '0) k++;
        end
        chk("no_stale_resp", 32'(k), 0);
        chk("post_rst_idle", 32'(busy), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
